// File: rtl/calc_key_entry.sv
// Calculator keypad front end: synchronise/debounce digit and operator buses, build a BCD operand, emit {operand, opcode}.
// Optional CALC_ENTRY_NEG_EN: key_sw[0] toggles a sign flag instead of acting as backspace.

module calc_key_entry_deb #(
  parameter int W          = 12,
  parameter int DEB_CYCLES = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] deb_o
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [W-1:0]  s1_q, s2_q, last_q, deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_d counts consecutive equal synchronised samples including the current one
  always_comb begin
    deb_d = deb_q;
    if (s2_q != last_q)                 cnt_d = CW'(1);
    else if (cnt_q != CW'(DEB_CYCLES))  cnt_d = cnt_q + 1'b1;
    else                                cnt_d = cnt_q;
    if (cnt_d == CW'(DEB_CYCLES))       deb_d = s2_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= '0;
      s2_q   <= '0;
      last_q <= '0;
      cnt_q  <= '0;
      deb_q  <= '0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      last_q <= s2_q;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

  assign deb_o = deb_q;
endmodule

module calc_key_entry #(
  parameter int NUM_OPS    = 8,
  parameter int NDIGITS    = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [11:0]                  key_sw,
  input  logic [NUM_OPS-1:0]           op_sw,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*NDIGITS-1:0]         out_bcd,
  output logic [$clog2(NUM_OPS)-1:0]   out_op,
  output logic                         out_neg,
  output logic [4*NDIGITS-1:0]         disp_bcd,
  output logic [$clog2(NDIGITS+1)-1:0] disp_cnt,
  output logic                         err
);
  localparam int DW = 4 * NDIGITS;
  localparam int OW = $clog2(NUM_OPS);
  localparam int CW = $clog2(NDIGITS + 1);

  typedef enum logic [1:0] {IDLE, ENTRY, EMIT} state_t;

  state_t        state_q, state_d;
  logic [11:0]   key_deb, key_prev_q;
  logic [NUM_OPS-1:0] op_deb, op_prev_q;
  logic [DW-1:0] entry_q, entry_d, out_bcd_q, out_bcd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] out_op_q, out_op_d, op_idx;
  logic          neg_q, neg_d, out_neg_q, out_neg_d;
  logic          out_valid_q, out_valid_d, err_q, err_d;
  logic          key_press, op_press, is_digit;
  logic [3:0]    digit;

  calc_key_entry_deb #(.W(12), .DEB_CYCLES(DEB_CYCLES)) u_key_deb (
    .clk_i(clk), .rst_ni(rst), .raw_i(key_sw), .deb_o(key_deb)
  );
  calc_key_entry_deb #(.W(NUM_OPS), .DEB_CYCLES(DEB_CYCLES)) u_op_deb (
    .clk_i(clk), .rst_ni(rst), .raw_i(op_sw), .deb_o(op_deb)
  );

  assign key_press = (key_prev_q == '0) && (key_deb != '0);
  assign op_press  = (op_prev_q == '0) && (op_deb != '0);

  // Key bit 2 is digit 0; bits 11..3 map to digits 1..9 (bit 11 = 1)
  always_comb begin
    digit    = '0;
    is_digit = 1'b0;
    op_idx   = '0;
    for (int unsigned i = 2; i < 12; i++) begin
      if (key_deb[i]) begin
        is_digit = 1'b1;
        digit    = (i == 2) ? 4'd0 : 4'(12 - i);
      end
    end
    for (int unsigned i = 0; i < NUM_OPS; i++) begin
      if (op_deb[i]) op_idx = OW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    out_valid_d = out_valid_q;
    out_bcd_d   = out_bcd_q;
    out_op_d    = out_op_q;
    out_neg_d   = out_neg_q;
    err_d       = 1'b0;
    if (state_q == EMIT) begin
      if (key_press || op_press) err_d = 1'b1;
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
        entry_d     = '0;
        cnt_d       = '0;
        neg_d       = 1'b0;
        state_d     = IDLE;
      end
    end else if (key_press && op_press) begin
      err_d = 1'b1;
    end else if (op_press) begin
      if (!$onehot(op_deb)) begin
        err_d = 1'b1;
      end else begin
        out_bcd_d   = entry_q;
        out_op_d    = op_idx;
        out_neg_d   = neg_q;
        out_valid_d = 1'b1;
        state_d     = EMIT;
      end
    end else if (key_press) begin
      if (!$onehot(key_deb)) begin
        err_d = 1'b1;
      end else if (is_digit) begin
        // entry is all-zero in IDLE, so the same shift serves the first digit
        if (cnt_q == CW'(NDIGITS)) begin
          err_d = 1'b1;
        end else begin
          entry_d = {entry_q[DW-5:0], digit};
          cnt_d   = cnt_q + 1'b1;
          state_d = ENTRY;
        end
      end else if (key_deb[1]) begin
        entry_d = '0;
        cnt_d   = '0;
        neg_d   = 1'b0;
        state_d = IDLE;
      end else begin
`ifdef CALC_ENTRY_NEG_EN
        neg_d = ~neg_q;
`else
        if (state_q == ENTRY) begin
          entry_d = {4'h0, entry_q[DW-1:4]};
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = IDLE;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      key_prev_q  <= '0;
      op_prev_q   <= '0;
      entry_q     <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
      out_op_q    <= '0;
      out_neg_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_prev_q  <= key_deb;
      op_prev_q   <= op_deb;
      entry_q     <= entry_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
      out_bcd_q   <= out_bcd_d;
      out_op_q    <= out_op_d;
      out_neg_q   <= out_neg_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;
  assign out_op    = out_op_q;
  assign out_neg   = out_neg_q;
  assign disp_bcd  = entry_q;
  assign disp_cnt  = cnt_q;
  assign err       = err_q;
endmodule

// File: tb/tb_calc_key_entry.sv
// Directed bench for calc_key_entry (NDIGITS=4, DEB_CYCLES=4, NUM_OPS=8).
module tb_calc_key_entry;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] key_sw = '0;
  logic [7:0]  op_sw = '0;
  logic        out_ready = 1'b0;
  logic        out_valid, out_neg, err;
  logic [15:0] out_bcd, disp_bcd;
  logic [2:0]  out_op, disp_cnt;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0, err_cnt = 0, valid_cyc = 0;
  logic [15:0] last_bcd = '0;
  logic [2:0]  last_op = '0;
  logic        last_neg = 1'b0;

  calc_key_entry #(.NUM_OPS(8), .NDIGITS(4), .DEB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .key_sw(key_sw), .op_sw(op_sw),
    .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd),
    .out_op(out_op), .out_neg(out_neg), .disp_bcd(disp_bcd),
    .disp_cnt(disp_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Observe on the falling edge; a handshake seen here completes on the next rising edge
  always @(negedge clk) begin
    if (err) err_cnt++;
    if (out_valid) valid_cyc++;
    if (out_valid && out_ready) begin
      hs_cnt++;
      last_bcd = out_bcd;
      last_op  = out_op;
      last_neg = out_neg;
    end
  end

  task automatic press(input logic [11:0] k, input logic [7:0] o);
    key_sw = k;
    op_sw  = o;
    repeat (10) @(posedge clk);
    #1;
    key_sw = '0;
    op_sw  = '0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_bcd, out_op, out_neg, disp_bcd, disp_cnt, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b bcd=%h op=%0d neg=%b disp=%h cnt=%0d err=%b, want all 0",
               out_valid, out_bcd, out_op, out_neg, disp_bcd, disp_cnt, err);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic_emit;
    int hs0, v0;
    out_ready = 1'b1;
    press(12'h400, 8'h00);
    press(12'h200, 8'h00);
    checks++;
    if (disp_bcd !== 16'h0023 || disp_cnt !== 3'd2) begin
      errors++;
      $display("FAIL basic_entry: got disp=%h cnt=%0d, want 0023 cnt=2", disp_bcd, disp_cnt);
    end
    hs0 = hs_cnt; v0 = valid_cyc;
    press(12'h000, 8'h80);
    checks++;
    if (hs_cnt - hs0 !== 1 || valid_cyc - v0 !== 1) begin
      errors++;
      $display("FAIL basic_handshake: got hs=%0d valid_cycles=%0d, want 1 and 1", hs_cnt - hs0, valid_cyc - v0);
    end
    checks++;
    if (last_bcd !== 16'h0023 || last_op !== 3'd7 || last_neg !== 1'b0) begin
      errors++;
      $display("FAIL basic_payload: got bcd=%h op=%0d neg=%b, want 0023 op=7 neg=0", last_bcd, last_op, last_neg);
    end
    checks++;
    if (out_valid !== 1'b0 || disp_cnt !== 3'd0 || disp_bcd !== 16'h0000) begin
      errors++;
      $display("FAIL basic_idle: got valid=%b cnt=%0d disp=%h, want 0 0 0000", out_valid, disp_cnt, disp_bcd);
    end
  endtask

  task automatic test_glitch;
    int e0;
    e0 = err_cnt;
    key_sw = 12'h100;
    repeat (3) @(posedge clk);
    #1;
    key_sw = '0;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (disp_cnt !== 3'd0 || err_cnt !== e0) begin
      errors++;
      $display("FAIL glitch: got cnt=%0d errs=%0d, want cnt=0 errs=0", disp_cnt, err_cnt - e0);
    end
  endtask

  task automatic test_overflow;
    int e0;
    e0 = err_cnt;
    press(12'h100, 8'h00);
    press(12'h080, 8'h00);
    press(12'h040, 8'h00);
    press(12'h400, 8'h00);
    checks++;
    if (err_cnt !== e0 || disp_bcd !== 16'h4562) begin
      errors++;
      $display("FAIL overflow_fill: got disp=%h errs=%0d, want 4562 errs=0", disp_bcd, err_cnt - e0);
    end
    press(12'h200, 8'h00);
    checks++;
    if (disp_bcd !== 16'h4562 || disp_cnt !== 3'd4 || err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL overflow_err: got disp=%h cnt=%0d errs=%0d, want 4562 cnt=4 errs=1",
               disp_bcd, disp_cnt, err_cnt - e0);
    end
    press(12'h002, 8'h00);
    checks++;
    if (disp_bcd !== 16'h0000 || disp_cnt !== 3'd0) begin
      errors++;
      $display("FAIL clear_entry: got disp=%h cnt=%0d, want 0000 cnt=0", disp_bcd, disp_cnt);
    end
  endtask

  task automatic test_backpressure;
    int e0, hs0;
    logic [15:0] exp_bcd;
    logic        exp_neg;
`ifdef CALC_ENTRY_NEG_EN
    exp_bcd = 16'h0078; exp_neg = 1'b1;
`else
    exp_bcd = 16'h0007; exp_neg = 1'b0;
`endif
    out_ready = 1'b0;
    press(12'h020, 8'h00);
    press(12'h010, 8'h00);
    press(12'h001, 8'h00);
    press(12'h000, 8'h40);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_bcd !== exp_bcd || out_op !== 3'd6 || out_neg !== exp_neg) begin
      errors++;
      $display("FAIL hold_payload: got valid=%b bcd=%h op=%0d neg=%b, want 1 %h op=6 neg=%b",
               out_valid, out_bcd, out_op, out_neg, exp_bcd, exp_neg);
    end
    e0 = err_cnt;
    press(12'h100, 8'h00);
    checks++;
    if (err_cnt - e0 !== 1 || disp_bcd !== exp_bcd || out_bcd !== exp_bcd || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL busy_key: got errs=%0d disp=%h bcd=%h valid=%b, want errs=1 disp=%h bcd=%h valid=1",
               err_cnt - e0, disp_bcd, out_bcd, out_valid, exp_bcd, exp_bcd);
    end
    hs0 = hs_cnt;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (hs_cnt - hs0 !== 1 || out_valid !== 1'b0 || disp_cnt !== 3'd0 || disp_bcd !== 16'h0000) begin
      errors++;
      $display("FAIL release_hold: got hs=%0d valid=%b cnt=%0d disp=%h, want 1 0 0 0000",
               hs_cnt - hs0, out_valid, disp_cnt, disp_bcd);
    end
  endtask

  task automatic test_multi_key;
    int e0, hs0;
    e0 = err_cnt; hs0 = hs_cnt;
    press(12'h600, 8'h00);
    checks++;
    if (err_cnt - e0 !== 1 || disp_cnt !== 3'd0) begin
      errors++;
      $display("FAIL multi_key: got errs=%0d cnt=%0d, want errs=1 cnt=0", err_cnt - e0, disp_cnt);
    end
    e0 = err_cnt;
    press(12'h100, 8'h01);
    checks++;
    if (err_cnt - e0 !== 1 || disp_cnt !== 3'd0 || hs_cnt !== hs0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL key_and_op: got errs=%0d cnt=%0d hs=%0d valid=%b, want errs=1 cnt=0 hs=0 valid=0",
               err_cnt - e0, disp_cnt, hs_cnt - hs0, out_valid);
    end
  endtask

  task automatic test_leading_zero;
    press(12'h004, 8'h00);
    checks++;
    if (disp_cnt !== 3'd1 || disp_bcd !== 16'h0000) begin
      errors++;
      $display("FAIL leading_zero: got cnt=%0d disp=%h, want cnt=1 disp=0000", disp_cnt, disp_bcd);
    end
    press(12'h008, 8'h00);
    checks++;
    if (disp_cnt !== 3'd2 || disp_bcd !== 16'h0009) begin
      errors++;
      $display("FAIL zero_then_nine: got cnt=%0d disp=%h, want cnt=2 disp=0009", disp_cnt, disp_bcd);
    end
    press(12'h002, 8'h00);
  endtask

`ifdef CALC_ENTRY_NEG_EN
  task automatic test_neg;
    out_ready = 1'b1;
    press(12'h008, 8'h00);
    press(12'h001, 8'h00);
    press(12'h000, 8'h01);
    checks++;
    if (last_bcd !== 16'h0009 || last_neg !== 1'b1 || last_op !== 3'd0) begin
      errors++;
      $display("FAIL neg_emit: got bcd=%h neg=%b op=%0d, want 0009 neg=1 op=0", last_bcd, last_neg, last_op);
    end
    press(12'h080, 8'h00);
    press(12'h000, 8'h01);
    checks++;
    if (last_bcd !== 16'h0005 || last_neg !== 1'b0) begin
      errors++;
      $display("FAIL neg_cleared: got bcd=%h neg=%b, want 0005 neg=0", last_bcd, last_neg);
    end
  endtask
`else
  task automatic test_backspace;
    int hs0;
    out_ready = 1'b1;
    press(12'h008, 8'h00);
    press(12'h001, 8'h00);
    checks++;
    if (disp_cnt !== 3'd0 || disp_bcd !== 16'h0000) begin
      errors++;
      $display("FAIL backspace_to_idle: got cnt=%0d disp=%h, want cnt=0 disp=0000", disp_cnt, disp_bcd);
    end
    hs0 = hs_cnt;
    press(12'h000, 8'h04);
    checks++;
    if (hs_cnt - hs0 !== 1 || last_bcd !== 16'h0000 || last_op !== 3'd2 || last_neg !== 1'b0) begin
      errors++;
      $display("FAIL idle_op: got hs=%0d bcd=%h op=%0d neg=%b, want hs=1 0000 op=2 neg=0",
               hs_cnt - hs0, last_bcd, last_op, last_neg);
    end
  endtask
`endif

  task automatic test_reset_mid_entry;
    press(12'h008, 8'h00);
    checks++;
    if (disp_cnt !== 3'd1 || disp_bcd !== 16'h0009) begin
      errors++;
      $display("FAIL pre_reset_entry: got cnt=%0d disp=%h, want cnt=1 disp=0009", disp_cnt, disp_bcd);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_bcd, out_op, out_neg, disp_bcd, disp_cnt, err} !== '0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b bcd=%h op=%0d neg=%b disp=%h cnt=%0d err=%b, want all 0",
               out_valid, out_bcd, out_op, out_neg, disp_bcd, disp_cnt, err);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset;
    test_basic_emit;
    test_glitch;
    test_overflow;
    test_backpressure;
    test_multi_key;
    test_leading_zero;
`ifdef CALC_ENTRY_NEG_EN
    test_neg;
`else
    test_backspace;
`endif
    test_reset_mid_entry;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
